// File: rtl/titan_lsu.sv
// titan_lsu: load/store unit that turns pipeline memory requests into single Wishbone B4 cycles.
// Optional feature macro TITAN_LSU_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYCLES cycles.
module titan_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic        lsu_mread_i,
   input  logic        lsu_mwrite_i,
   input  logic        lsu_mword_i,
   input  logic        lsu_mhw_i,
   input  logic        lsu_mbyte_i,
   input  logic        lsu_munsigned_i,
   input  logic        lsu_kill_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_err_o,
   output logic        lsu_stall_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t      state_reg, state_next;
   logic        aligned, req_valid, timeout;
   logic [3:0]  sel_req;
   logic [31:0] wdat_req;
   logic        cyc_reg, cyc_next;
   logic        we_reg, we_next;
   logic [31:0] addr_reg, addr_next;
   logic [3:0]  sel_reg, sel_next;
   logic [31:0] wdat_reg, wdat_next;
   logic [31:0] rdata_reg, rdata_next;
   logic [1:0]  off_reg, off_next;
   logic        word_reg, word_next;
   logic        hw_reg, hw_next;
   logic        uns_reg, uns_next;
   logic        load_reg, load_next;
   logic        err_reg, err_next;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] fmt_data;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("titan_lsu: TIMEOUT_CYCLES must lie in 1..65535");
   end

   // Size priority is word, then halfword, otherwise byte (byte is always aligned).
   always_comb begin
      aligned  = 1'b1;
      sel_req  = 4'b0001 << lsu_addr_i[1:0];
      wdat_req = {4{lsu_wdata_i[7:0]}};
      if (lsu_mword_i) begin
         aligned  = (lsu_addr_i[1:0] == 2'b00);
         sel_req  = 4'b1111;
         wdat_req = lsu_wdata_i;
      end else if (lsu_mhw_i) begin
         aligned  = ~lsu_addr_i[0];
         sel_req  = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
         wdat_req = {2{lsu_wdata_i[15:0]}};
      end
   end

   assign req_valid = (lsu_mread_i | lsu_mwrite_i) & aligned & ~lsu_kill_i;

`ifdef TITAN_LSU_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         tmo_cnt_reg <= '0;
      end else if (state_reg == BUSY) begin
         tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
   end

   assign timeout = (state_reg == BUSY) && (tmo_cnt_reg == TMO_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cyc_next   = cyc_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      sel_next   = sel_reg;
      wdat_next  = wdat_reg;
      rdata_next = rdata_reg;
      off_next   = off_reg;
      word_next  = word_reg;
      hw_next    = hw_reg;
      uns_next   = uns_reg;
      load_next  = load_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               state_next = BUSY;
               cyc_next   = 1'b1;
               we_next    = lsu_mwrite_i;
               addr_next  = {lsu_addr_i[31:2], 2'b00};
               sel_next   = sel_req;
               wdat_next  = wdat_req;
               rdata_next = '0;
               off_next   = lsu_addr_i[1:0];
               word_next  = lsu_mword_i;
               hw_next    = lsu_mhw_i;
               uns_next   = lsu_munsigned_i;
               load_next  = ~lsu_mwrite_i;
               err_next   = 1'b0;
            end
         end
         BUSY: begin
            // Kill beats any bus response; err beats ack.
            if (lsu_kill_i) begin
               state_next = IDLE;
               cyc_next   = 1'b0;
            end else if (wbm_err_i || timeout) begin
               state_next = DONE;
               cyc_next   = 1'b0;
               err_next   = 1'b1;
            end else if (wbm_ack_i) begin
               state_next = DONE;
               cyc_next   = 1'b0;
               rdata_next = wbm_dat_i;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         sel_reg   <= '0;
         wdat_reg  <= '0;
         rdata_reg <= '0;
         off_reg   <= '0;
         word_reg  <= 1'b0;
         hw_reg    <= 1'b0;
         uns_reg   <= 1'b0;
         load_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         cyc_reg   <= cyc_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         sel_reg   <= sel_next;
         wdat_reg  <= wdat_next;
         rdata_reg <= rdata_next;
         off_reg   <= off_next;
         word_reg  <= word_next;
         hw_reg    <= hw_next;
         uns_reg   <= uns_next;
         load_reg  <= load_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      case (off_reg)
         2'd0:    byte_lane = rdata_reg[7:0];
         2'd1:    byte_lane = rdata_reg[15:8];
         2'd2:    byte_lane = rdata_reg[23:16];
         default: byte_lane = rdata_reg[31:24];
      endcase
      half_lane = off_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
      if (word_reg)
         fmt_data = rdata_reg;
      else if (hw_reg)
         fmt_data = {{16{half_lane[15] & ~uns_reg}}, half_lane};
      else
         fmt_data = {{24{byte_lane[7] & ~uns_reg}}, byte_lane};
   end

   assign lsu_data_o  = (state_reg == DONE && load_reg && !err_reg) ? fmt_data : 32'h0;
   assign lsu_err_o   = (state_reg == DONE) && err_reg;
   assign lsu_stall_o = ~rst_i & (((state_reg == IDLE) & req_valid) | (state_reg == BUSY));

   assign wbm_cyc_o  = cyc_reg;
   assign wbm_stb_o  = cyc_reg;
   assign wbm_we_o   = we_reg;
   assign wbm_addr_o = addr_reg;
   assign wbm_sel_o  = sel_reg;
   assign wbm_dat_o  = wdat_reg;

endmodule

// File: tb/tb_titan_lsu.sv
// Self-checking bench for titan_lsu: scenario tasks with a scoreboard of expected load responses.
module tb_titan_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_mread_i, lsu_mwrite_i, lsu_mword_i, lsu_mhw_i, lsu_mbyte_i;
   logic        lsu_munsigned_i, lsu_kill_i;
   logic [31:0] lsu_data_o;
   logic        lsu_err_o, lsu_stall_o;
   logic [31:0] wbm_addr_o, wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   titan_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_mread_i(lsu_mread_i), .lsu_mwrite_i(lsu_mwrite_i),
      .lsu_mword_i(lsu_mword_i), .lsu_mhw_i(lsu_mhw_i), .lsu_mbyte_i(lsu_mbyte_i),
      .lsu_munsigned_i(lsu_munsigned_i), .lsu_kill_i(lsu_kill_i),
      .lsu_data_o(lsu_data_o), .lsu_err_o(lsu_err_o), .lsu_stall_o(lsu_stall_o),
      .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   // Reference load formatter: sz 0=byte, 1=halfword, 2=word.
   function automatic logic [31:0] fmt_load(input logic [31:0] bus, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
      logic [31:0] sh;
      if (sz == 2'd2) return bus;
      if (sz == 2'd1) begin
         sh = off[1] ? (bus >> 16) : bus;
         return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      sh = bus >> (8 * off);
      return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
   endfunction

   task automatic idle_inputs();
      lsu_addr_i = '0; lsu_wdata_i = '0;
      lsu_mread_i = 0; lsu_mwrite_i = 0;
      lsu_mword_i = 0; lsu_mhw_i = 0; lsu_mbyte_i = 0;
      lsu_munsigned_i = 0; lsu_kill_i = 0;
      wbm_ack_i = 0; wbm_err_i = 0;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns);
      lsu_addr_i = a; lsu_wdata_i = wd;
      lsu_mread_i = rd; lsu_mwrite_i = wr;
      lsu_mword_i = (sz == 2'd2); lsu_mhw_i = (sz == 2'd1); lsu_mbyte_i = (sz == 2'd0);
      lsu_munsigned_i = uns;
   endtask

   task automatic test_reset();
      issue(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0, 2'd2, 1'b0);
      #1;
      checks++;
      if (lsu_stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b expected 0", lsu_stall_o);
      end
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'h0 || wbm_addr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin
         errors++; $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h expected all 0",
                            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o);
      end
      checks++;
      if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0) begin
         errors++; $display("FAIL reset_resp: got data=%h err=%b expected 0/0", lsu_data_o, lsu_err_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      idle_inputs();
      @(negedge clk_i);
      $display("txn reset: done");
   endtask

   task automatic test_byte_load();
      exp_t e;
      int   stall_cycles = 0;
      @(negedge clk_i);
      issue(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
      e.data = fmt_load(32'h80FF_FF00, 2'd3, 2'd0, 1'b0); e.err = 1'b0;
      sb_q.push_back(e);
      #1 if (lsu_stall_o) stall_cycles++;
      @(negedge clk_i);
      idle_inputs();
      #1 if (lsu_stall_o) stall_cycles++;
      checks++;
      if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b0) begin
         errors++; $display("FAIL byte_load_ctrl: got cyc=%b stb=%b we=%b expected 1/1/0", wbm_cyc_o, wbm_stb_o, wbm_we_o);
      end
      checks++;
      if (wbm_sel_o !== 4'b1000) begin
         errors++; $display("FAIL byte_load_sel: got %b expected 1000", wbm_sel_o);
      end
      checks++;
      if (wbm_addr_o !== 32'h0000_1000) begin
         errors++; $display("FAIL byte_load_addr: got %h expected 00001000", wbm_addr_o);
      end
      wbm_dat_i = 32'h80FF_FF00; wbm_ack_i = 1'b1;
      @(negedge clk_i);
      wbm_ack_i = 1'b0;
      #1 if (lsu_stall_o) stall_cycles++;
      e = sb_q.pop_front();
      checks++;
      if (lsu_data_o !== e.data || lsu_err_o !== e.err) begin
         errors++; $display("FAIL byte_load_data: got %h/%b expected %h/%b", lsu_data_o, lsu_err_o, e.data, e.err);
      end
      checks++;
      if (wbm_cyc_o !== 1'b0) begin
         errors++; $display("FAIL byte_load_cyc_drop: got %b expected 0", wbm_cyc_o);
      end
      checks++;
      if (stall_cycles !== 2) begin
         errors++; $display("FAIL byte_load_stall_len: got %0d expected 2", stall_cycles);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (lsu_data_o !== 32'h0) begin
         errors++; $display("FAIL byte_load_done_len: got %h expected 0", lsu_data_o);
      end
      $display("txn byte_load: addr=00001003 data=%h", e.data);
   endtask

   task automatic test_hw_store();
      @(negedge clk_i);
      issue(32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      #1;
      checks++;
      if (wbm_sel_o !== 4'b1100 || wbm_dat_o !== 32'hBEEF_BEEF || wbm_we_o !== 1'b1 || wbm_addr_o !== 32'h0000_2000) begin
         errors++; $display("FAIL hw_store_bus: got sel=%b dat=%h we=%b addr=%h expected 1100/beefbeef/1/00002000",
                            wbm_sel_o, wbm_dat_o, wbm_we_o, wbm_addr_o);
      end
      wbm_dat_i = 32'hDEAD_BEEF; wbm_ack_i = 1'b1;
      @(negedge clk_i);
      wbm_ack_i = 1'b0;
      #1;
      checks++;
      if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++; $display("FAIL hw_store_done: got data=%h err=%b stall=%b expected 0/0/0", lsu_data_o, lsu_err_o, lsu_stall_o);
      end
      $display("txn hw_store: addr=00002002 sel=1100");
   endtask

   task automatic test_misaligned();
      int bad = 0;
      @(negedge clk_i);
      issue(32'h0000_3001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 if (wbm_cyc_o !== 1'b0 || lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0) bad++;
         @(negedge clk_i);
      end
      issue(32'h0000_3003, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 if (wbm_cyc_o !== 1'b0 || lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0) bad++;
         @(negedge clk_i);
      end
      idle_inputs();
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL misaligned: got %0d active cycles expected 0", bad);
      end
      $display("txn misaligned: addr=00003001/00003003 ignored");
   endtask

   task automatic test_bus_error();
      @(negedge clk_i);
      issue(32'h0000_5000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b1 || lsu_stall_o !== 1'b1) begin
         errors++; $display("FAIL bus_err_wait: got cyc=%b stall=%b expected 1/1", wbm_cyc_o, lsu_stall_o);
      end
      wbm_dat_i = 32'hFFFF_FFFF; wbm_err_i = 1'b1; wbm_ack_i = 1'b1;
      @(negedge clk_i);
      wbm_err_i = 1'b0; wbm_ack_i = 1'b0;
      #1;
      checks++;
      if (lsu_err_o !== 1'b1 || lsu_data_o !== 32'h0 || wbm_cyc_o !== 1'b0) begin
         errors++; $display("FAIL bus_err_done: got err=%b data=%h cyc=%b expected 1/0/0", lsu_err_o, lsu_data_o, wbm_cyc_o);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (lsu_err_o !== 1'b0) begin
         errors++; $display("FAIL bus_err_len: got %b expected 0", lsu_err_o);
      end
      $display("txn bus_error: addr=00005000 err=1");
   endtask

   task automatic test_kill_ack();
      int seen = 0;
      @(negedge clk_i);
      issue(32'h0000_4000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      lsu_kill_i = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
      @(negedge clk_i);
      idle_inputs();
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++; $display("FAIL kill_drop: got cyc=%b stall=%b expected 0/0", wbm_cyc_o, lsu_stall_o);
      end
      for (int i = 0; i < 3; i++) begin
         if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0) seen++;
         @(negedge clk_i);
         #1;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL kill_no_done: got %0d response cycles expected 0", seen);
      end
      $display("txn kill_ack: addr=00004000 killed");
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] a, wd, bus, exp_dat;
      logic [1:0]  sz;
      logic [3:0]  exp_sel;
      logic        wr, uns;
      int          waits;
      for (int n = 0; n < 10; n++) begin
         a = $urandom; wd = $urandom; bus = $urandom;
         sz = 2'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         waits = $urandom_range(0, 3);
         if (sz == 2'd2) a[1:0] = 2'b00;
         if (sz == 2'd1) a[0] = 1'b0;
         exp_sel = (sz == 2'd2) ? 4'hF : (sz == 2'd1) ? (a[1] ? 4'hC : 4'h3) : (4'h1 << a[1:0]);
         exp_dat = (sz == 2'd2) ? wd : (sz == 2'd1) ? {wd[15:0], wd[15:0]} : {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         e.data = wr ? 32'h0 : fmt_load(bus, a[1:0], sz, uns); e.err = 1'b0;
         @(negedge clk_i);
         issue(a, wd, ~wr, wr, sz, uns);
         sb_q.push_back(e);
         @(negedge clk_i);
         idle_inputs();
         #1;
         checks++;
         if (wbm_sel_o !== exp_sel || wbm_dat_o !== exp_dat || wbm_we_o !== wr || wbm_addr_o !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL b2b_bus[%0d]: got sel=%h dat=%h we=%b addr=%h expected %h/%h/%b/%h",
                               n, wbm_sel_o, wbm_dat_o, wbm_we_o, wbm_addr_o, exp_sel, exp_dat, wr, {a[31:2], 2'b00});
         end
         repeat (waits) @(negedge clk_i);
         wbm_dat_i = bus; wbm_ack_i = 1'b1;
         @(negedge clk_i);
         wbm_ack_i = 1'b0;
         #1;
         e = sb_q.pop_front();
         checks++;
         if (lsu_data_o !== e.data || lsu_err_o !== e.err || lsu_stall_o !== 1'b0) begin
            errors++; $display("FAIL b2b_resp[%0d]: got data=%h err=%b stall=%b expected %h/%b/0",
                               n, lsu_data_o, lsu_err_o, lsu_stall_o, e.data, e.err);
         end
         $display("txn b2b[%0d]: addr=%h sz=%0d we=%b uns=%b waits=%0d data=%h", n, a, sz, wr, uns, waits, e.data);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      issue(32'h0000_7000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      #1 rst_i = 1'b1;
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_drop: got cyc=%b stb=%b stall=%b expected 0/0/0", wbm_cyc_o, wbm_stb_o, lsu_stall_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
      @(negedge clk_i);
      wbm_ack_i = 1'b0;
      #1;
      checks++;
      if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_discard: got data=%h err=%b cyc=%b expected 0/0/0", lsu_data_o, lsu_err_o, wbm_cyc_o);
      end
      $display("txn reset_mid: addr=00007000 aborted");
   endtask

   task automatic test_no_ack();
      int n = 0;
      @(negedge clk_i);
      issue(32'h0000_6000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      #1;
`ifdef TITAN_LSU_TIMEOUT_EN
      while (lsu_stall_o && n < 50) begin
         n++;
         @(negedge clk_i);
         #1;
      end
      checks++;
      if (n !== 4) begin
         errors++; $display("FAIL timeout_len: got %0d busy cycles expected 4", n);
      end
      checks++;
      if (lsu_err_o !== 1'b1 || lsu_data_o !== 32'h0 || wbm_cyc_o !== 1'b0) begin
         errors++; $display("FAIL timeout_done: got err=%b data=%h cyc=%b expected 1/0/0", lsu_err_o, lsu_data_o, wbm_cyc_o);
      end
      $display("txn no_ack: timed out after %0d cycles", n);
`else
      for (int i = 0; i < 1000; i++) begin
         if (wbm_cyc_o !== 1'b1 || lsu_stall_o !== 1'b1 || lsu_err_o !== 1'b0) n++;
         @(negedge clk_i);
         #1;
      end
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL no_ack_hold: got %0d non-busy cycles expected 0", n);
      end
      lsu_kill_i = 1'b1;
      @(negedge clk_i);
      lsu_kill_i = 1'b0;
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++; $display("FAIL no_ack_kill: got cyc=%b stall=%b expected 0/0", wbm_cyc_o, lsu_stall_o);
      end
      $display("txn no_ack: still busy after 1000 cycles");
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1;
      wbm_dat_i = '0;
      idle_inputs();
      test_reset();
      test_byte_load();
      test_hw_store();
      test_misaligned();
      test_bus_error();
      test_kill_ack();
      test_back_to_back();
      test_reset_mid();
      test_no_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
